// File: rtl/regaddr_seq.sv
// Operand-addressing sequencer for the PDP-11 datapath.
// Drives the regfile port (sela/selb/we/w) and consumes bus A. It performs the
// register reads, autoinc/autodec writebacks and PC-relative index fetch, then
// presents the effective address to the operand stage.
// Optional feature: define REGSEQ_STACK_CHECK_EN to flag an SP autodecrement
// below STACK_LIMIT on stk_err.
module regaddr_seq #(
  parameter int unsigned     W           = 16,
  parameter logic [W-1:0]    STACK_LIMIT = W'(16'o400)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   mode,
  input  logic [2:0]   rn,
  input  logic         byte_op,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] ea,
  output logic         is_reg,
  output logic         indirect,
  output logic         stk_err,
  output logic [2:0]   rf_sela,
  output logic [2:0]   rf_selb,
  output logic         rf_we,
  output logic [W-1:0] rf_w,
  input  logic [W-1:0] rf_a,
  output logic         mem_req,
  output logic [W-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StPcrd, StMem, StPcwr, StRd, StWr, StDone} state_e;

  state_e       state_q, state_d;
  logic [2:0]   mode_q, mode_d;
  logic [2:0]   rn_q, rn_d;
  logic         byte_op_q, byte_op_d;
  logic [W-1:0] x_q, x_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] ea_q, ea_d;
  logic         is_reg_q, is_reg_d;
  logic         indirect_q, indirect_d;
  logic [2:0]   rf_sela_q, rf_sela_d;
  logic [2:0]   rf_selb_q, rf_selb_d;
  logic         rf_we_q, rf_we_d;
  logic [W-1:0] rf_w_q, rf_w_d;
  logic         mem_req_q, mem_req_d;
  // Doubles as the captured PC for the index fetch and the PC+2 writeback.
  logic [W-1:0] mem_addr_q, mem_addr_d;
  logic [W-1:0] inc;
`ifdef REGSEQ_STACK_CHECK_EN
  logic         stk_err_q, stk_err_d;
`else
  logic         unused_stack_limit;
  assign unused_stack_limit = ^STACK_LIMIT;
`endif

  // Next-state, datapath captures and registered-output values for the next cycle.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    rn_d       = rn_q;
    byte_op_d  = byte_op_q;
    x_d        = x_q;
    ea_d       = ea_q;
    is_reg_d   = is_reg_q;
    indirect_d = indirect_q;
    rf_selb_d  = rf_selb_q;
    rf_w_d     = rf_w_q;
    mem_addr_d = mem_addr_q;
`ifdef REGSEQ_STACK_CHECK_EN
    stk_err_d  = 1'b0;
`endif
    // Byte step only for plain autoinc/autodec on R0-R5; SP/PC and deferred modes stay word-aligned.
    inc = ((byte_op_q && (mode_q == 3'd2 || mode_q == 3'd4) && rn_q < 3'd6)) ? W'(1) : W'(2);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d    = mode;
          rn_d      = rn;
          byte_op_d = byte_op;
          state_d   = (mode[2:1] == 2'b11) ? StPcrd : StRd;
        end
      end
      StPcrd: begin
        mem_addr_d = rf_a;
        state_d    = StMem;
      end
      StMem: begin
        if (mem_ack) begin
          x_d       = mem_rdata;
          rf_selb_d = 3'd7;
          rf_w_d    = mem_addr_q + W'(2);
          state_d   = StPcwr;
        end
      end
      StPcwr: state_d = StRd;
      StRd: begin
        is_reg_d   = (mode_q == 3'd0);
        indirect_d = mode_q[0] && (mode_q[2:1] != 2'b00);
        unique case (mode_q[2:1])
          2'b00: begin
            ea_d    = rf_a;
            state_d = StDone;
          end
          2'b01: begin
            ea_d      = rf_a;
            rf_w_d    = rf_a + inc;
            rf_selb_d = rn_q;
            state_d   = StWr;
          end
          2'b10: begin
            ea_d      = rf_a - inc;
            rf_w_d    = rf_a - inc;
            rf_selb_d = rn_q;
            state_d   = StWr;
          end
          default: begin
            ea_d    = rf_a + x_q;
            state_d = StDone;
          end
        endcase
      end
      StWr: begin
`ifdef REGSEQ_STACK_CHECK_EN
        stk_err_d = (mode_q[2:1] == 2'b10) && (rn_q == 3'd6) && (rf_w_q < STACK_LIMIT);
`endif
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
    rf_we_d   = (state_d == StWr) || (state_d == StPcwr);
    mem_req_d = (state_d == StMem);
    rf_sela_d = (state_d == StRd) ? rn_d : (state_d == StPcrd) ? 3'd7 : 3'd0;
  end

  // All state and outputs registered; synchronous reset aborts any sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mode_q     <= 3'd0;
      rn_q       <= 3'd0;
      byte_op_q  <= 1'b0;
      x_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ea_q       <= '0;
      is_reg_q   <= 1'b0;
      indirect_q <= 1'b0;
      rf_sela_q  <= 3'd0;
      rf_selb_q  <= 3'd0;
      rf_we_q    <= 1'b0;
      rf_w_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
`ifdef REGSEQ_STACK_CHECK_EN
      stk_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rn_q       <= rn_d;
      byte_op_q  <= byte_op_d;
      x_q        <= x_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ea_q       <= ea_d;
      is_reg_q   <= is_reg_d;
      indirect_q <= indirect_d;
      rf_sela_q  <= rf_sela_d;
      rf_selb_q  <= rf_selb_d;
      rf_we_q    <= rf_we_d;
      rf_w_q     <= rf_w_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
`ifdef REGSEQ_STACK_CHECK_EN
      stk_err_q  <= stk_err_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ea       = ea_q;
  assign is_reg   = is_reg_q;
  assign indirect = indirect_q;
  assign rf_sela  = rf_sela_q;
  assign rf_selb  = rf_selb_q;
  assign rf_we    = rf_we_q;
  assign rf_w     = rf_w_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
`ifdef REGSEQ_STACK_CHECK_EN
  assign stk_err  = stk_err_q;
`else
  assign stk_err  = 1'b0;
`endif

endmodule

// File: tb/tb_regaddr_seq.sv
// Scoreboard bench for regaddr_seq: stimulus pushes expected results, a monitor
// pops and compares them whenever done pulses. Includes a regfile model and a
// memory responder with programmable wait cycles.
module tb_regaddr_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic [2:0]   rn = 3'd0;
  logic         byte_op = 1'b0;
  logic         busy, done, is_reg, indirect, stk_err, rf_we, mem_req;
  logic [W-1:0] ea, rf_w, rf_a, mem_addr;
  logic [2:0]   rf_sela, rf_selb;
  logic         mem_ack = 1'b0;
  logic [W-1:0] mem_rdata = '0;

  regaddr_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .rn(rn), .byte_op(byte_op),
    .busy(busy), .done(done), .ea(ea), .is_reg(is_reg), .indirect(indirect),
    .stk_err(stk_err), .rf_sela(rf_sela), .rf_selb(rf_selb), .rf_we(rf_we), .rf_w(rf_w),
    .rf_a(rf_a), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0o, expected %0o", name, act, req);
    end
  endtask

  // Regfile model: combinational read on bus A, write on clock; bench preloads via ld_*.
  logic [W-1:0] regs [8];
  logic         ld_en = 1'b0;
  logic [2:0]   ld_idx = 3'd0;
  logic [W-1:0] ld_val = '0;
  assign rf_a = regs[rf_sela];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (ld_en) regs[ld_idx] <= ld_val;
      if (rf_we) regs[rf_selb] <= rf_w;
    end
  end

  // Memory responder: acks after mem_wait cycles of mem_req; optional spurious ack when idle.
  int           mem_wait = 0;
  int           wcnt = 0;
  logic [W-1:0] mem_x = '0;
  logic [W-1:0] exp_maddr = '0;
  logic         spur = 1'b0;

  always @(negedge clk) begin
    if (mem_req && !reset) begin
      if (wcnt == mem_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_x;
        check("mem_addr", 32'(mem_addr), 32'(exp_maddr));
      end else begin
        mem_ack = 1'b0;
      end
      wcnt++;
    end else begin
      wcnt      = 0;
      mem_ack   = spur;
      mem_rdata = 16'o177777;
    end
  end

  typedef struct {
    string        name;
    logic [W-1:0] ea;
    logic         is_reg;
    logic         indirect;
    logic         stk;
    int           lat;
    bit           wb_en;
    int           wb_idx;
    logic [W-1:0] wb_val;
  } exp_t;

  exp_t sb[$];
  int   bcount = 0;

  // Monitor: counts busy cycles and checks each done against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      bcount = 0;
    end else begin
      if (busy) bcount++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          e = sb.pop_front();
          check({e.name, ".ea"}, 32'(ea), 32'(e.ea));
          check({e.name, ".is_reg"}, 32'(is_reg), 32'(e.is_reg));
          check({e.name, ".indirect"}, 32'(indirect), 32'(e.indirect));
          check({e.name, ".stk_err"}, 32'(stk_err), 32'(e.stk));
          check({e.name, ".latency"}, 32'(bcount), 32'(e.lat));
          if (e.wb_en) check({e.name, ".regfile"}, 32'(regs[e.wb_idx]), 32'(e.wb_val));
        end
        bcount = 0;
      end
    end
  end

  task automatic load(input int idx, input logic [W-1:0] val);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_idx = 3'(idx);
    ld_val = val;
    @(negedge clk);
    ld_en  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'(0));
  endtask

  // hold > 1 keeps start high into the busy period with a different mode (must be ignored).
  task automatic issue(input string name, input int m, input int r, input bit b,
                       input logic [W-1:0] x_ea, input bit x_reg, input bit x_ind,
                       input bit x_stk, input int lat, input bit wb_en, input int wb_idx,
                       input logic [W-1:0] wb_val, input int hold);
    exp_t e;
    e.name = name; e.ea = x_ea; e.is_reg = x_reg; e.indirect = x_ind; e.stk = x_stk;
    e.lat = lat; e.wb_en = wb_en; e.wb_idx = wb_idx; e.wb_val = wb_val;
    @(negedge clk);
    mode = 3'(m); rn = 3'(r); byte_op = b; start = 1'b1;
    sb.push_back(e);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      mode = 3'd0; rn = 3'd5;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    bit stk_exp;
`ifdef REGSEQ_STACK_CHECK_EN
    stk_exp = 1'b1;
`else
    stk_exp = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.rf_we", 32'(rf_we), 0);
    check("rst.mem_req", 32'(mem_req), 0);
    check("rst.outs", {ea, 13'(0), is_reg, indirect, stk_err}, 0);
    check("rst.sel", {26'(0), rf_sela, rf_selb}, 0);
    check("rst.data", {rf_w, mem_addr}, 0);
    reset = 1'b0;

    load(3, 16'o001000);
    issue("m2_r3", 2, 3, 0, 16'o001000, 0, 0, 0, 3, 1, 3, 16'o001002, 1);
    load(2, 16'o001000);
    issue("m4_r2_byte", 4, 2, 1, 16'o000777, 0, 0, 0, 3, 1, 2, 16'o000777, 2);
    load(6, 16'o001000);
    issue("m4_sp_byte", 4, 6, 1, 16'o000776, 0, 0, 0, 3, 1, 6, 16'o000776, 1);

    load(7, 16'o002000);
    load(3, 16'o001000);
    mem_wait = 2; mem_x = 16'o000100; exp_maddr = 16'o002000;
    issue("m6_r3", 6, 3, 0, 16'o001100, 0, 0, 0, 7, 1, 7, 16'o002002, 1);

    load(7, 16'o002000);
    mem_wait = 0; mem_x = 16'o000010; exp_maddr = 16'o002000; spur = 1'b1;
    issue("m7_pc", 7, 7, 0, 16'o002012, 0, 1, 0, 5, 1, 7, 16'o002002, 1);
    spur = 1'b0;

    load(6, 16'o000400);
    issue("m4_sp_limit", 4, 6, 0, 16'o000376, 0, 0, stk_exp, 3, 1, 6, 16'o000376, 1);
    load(6, 16'o000402);
    issue("m5_sp_ok", 5, 6, 0, 16'o000400, 0, 1, 0, 3, 1, 6, 16'o000400, 1);

    load(5, 16'o123456);
    issue("m0_r5", 0, 5, 0, 16'o123456, 1, 0, 0, 2, 1, 5, 16'o123456, 1);
    load(1, 16'o004444);
    issue("m1_r1", 1, 1, 1, 16'o004444, 0, 0, 0, 2, 1, 1, 16'o004444, 1);
    load(4, 16'o177777);
    issue("m3_r4_wrap", 3, 4, 1, 16'o177777, 0, 1, 0, 3, 1, 4, 16'o000001, 1);
    load(0, 16'o000000);
    issue("m5_r0_wrap", 5, 0, 0, 16'o177776, 0, 1, 0, 3, 1, 0, 16'o177776, 1);
    load(7, 16'o001000);
    issue("m2_pc_byte", 2, 7, 1, 16'o001000, 0, 0, 0, 3, 1, 7, 16'o001002, 1);

    // Abort a mode 6 sequence while parked in MEM.
    load(7, 16'o002000);
    mem_wait = 50; exp_maddr = 16'o002000;
    @(negedge clk);
    mode = 3'd6; rn = 3'd3; byte_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    check("abort.mem_req_seen", 32'(mem_req), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort.mem_req", 32'(mem_req), 0);
    check("abort.busy", 32'(busy), 0);
    check("abort.rf_we", 32'(rf_we), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.pc", 32'(regs[7]), 0);
    issue("post_abort_m0", 0, 7, 0, 16'o000000, 1, 0, 0, 2, 1, 7, 16'o000000, 1);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
